// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped write-through no-write-allocate data cache with miss-fill FSM,
// flush and saturating read hit/miss counters.
module dm_cache_ctrl #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic [DATA_WIDTH-1:0]  iAddress,
  input  logic [DATA_WIDTH-1:0]  iWriteData,
  input  logic                   iRead,
  input  logic                   iWrite,
  input  logic                   iFlush,
  output logic [DATA_WIDTH-1:0]  oData,
  output logic                   oHit,
  output logic                   oStall,
  output logic                   oMemReq,
  output logic                   oMemWe,
  output logic [DATA_WIDTH-1:0]  oMemAddr,
  output logic [DATA_WIDTH-1:0]  oMemWData,
  input  logic                   iMemAck,
  input  logic [DATA_WIDTH-1:0]  iMemRData,
  output logic [COUNT_WIDTH-1:0] oHitCount,
  output logic [COUNT_WIDTH-1:0] oMissCount
);
  localparam int LINES = 1 << ADDRESS_WIDTH;
  localparam int TW    = DATA_WIDTH - ADDRESS_WIDTH - 2;
  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;
  state_t state, state_nx;
  logic [LINES-1:0]        valid;
  logic [DATA_WIDTH-1:0]   data_mem [LINES];
  logic [TW-1:0]           tag_mem  [LINES];
  logic [DATA_WIDTH-3:0]   lat_word;
  logic [DATA_WIDTH-1:0]   lat_data;
  logic [ADDRESS_WIDTH-1:0] idx, lat_idx;
  logic [TW-1:0]           tag, lat_tag;
  logic idle, line_hit, do_flush, do_write, do_read, fill, unused_ok;
  assign idx       = iAddress[ADDRESS_WIDTH+1:2];
  assign tag       = iAddress[DATA_WIDTH-1:ADDRESS_WIDTH+2];
  assign lat_idx   = lat_word[ADDRESS_WIDTH-1:0];
  assign lat_tag   = lat_word[DATA_WIDTH-3:ADDRESS_WIDTH];
  assign unused_ok = ^iAddress[1:0];
  assign line_hit  = valid[idx] && tag_mem[idx] == tag;
  // Gating with reset keeps the un-reset arrays untouched while reset is held.
  assign idle      = state == IDLE && iRST_N;
  assign do_flush  = idle && iFlush;
  assign do_write  = idle && !iFlush && iWrite;
  assign do_read   = idle && !iFlush && !iWrite && iRead;
  assign fill      = state == FETCH && iMemAck;
  assign oMemAddr  = {lat_word, 2'b00};
  assign oMemWData = lat_data;
  always_comb begin
    state_nx = state;
    oStall   = 1'b0;
    oHit     = 1'b0;
    oData    = '0;
    oMemReq  = 1'b0;
    oMemWe   = 1'b0;
    case (state)
      IDLE: begin
        oHit     = do_read && line_hit;
        oData    = oHit ? data_mem[idx] : '0;
        oStall   = do_flush || do_write || (do_read && !line_hit);
        state_nx = do_write ? WRITE : (do_read && !line_hit) ? FETCH : IDLE;
      end
      FETCH: begin
        oMemReq  = 1'b1;
        oStall   = !iMemAck;
        oData    = iMemAck ? iMemRData : '0;
        state_nx = iMemAck ? IDLE : FETCH;
      end
      WRITE: begin
        oMemReq  = 1'b1;
        oMemWe   = 1'b1;
        oStall   = !iMemAck;
        state_nx = iMemAck ? IDLE : WRITE;
      end
      default: state_nx = IDLE;
    endcase
    if (!iRST_N) begin
      oStall  = 1'b0;
      oHit    = 1'b0;
      oData   = '0;
      oMemReq = 1'b0;
      oMemWe  = 1'b0;
    end
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) state <= IDLE;
    else         state <= state_nx;
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      valid      <= '0;
      lat_word   <= '0;
      lat_data   <= '0;
      oHitCount  <= '0;
      oMissCount <= '0;
    end else begin
      if (do_flush) valid <= '0;
      if (fill) valid[lat_idx] <= 1'b1;
      if (do_write || (do_read && !line_hit)) lat_word <= iAddress[DATA_WIDTH-1:2];
      if (do_write) lat_data <= iWriteData;
      if (do_read && line_hit && !(&oHitCount)) oHitCount <= oHitCount + 1'b1;
      if (do_read && !line_hit && !(&oMissCount)) oMissCount <= oMissCount + 1'b1;
    end
  end
  always_ff @(posedge iCLK)
    if (fill) begin
      data_mem[lat_idx] <= iMemRData;
      tag_mem[lat_idx]  <= lat_tag;
    end else if (do_write && line_hit) data_mem[idx] <= iWriteData;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed bench with a line-level cache model checked every cycle,
// plus literal expectations; a COUNT_WIDTH=2 twin exercises counter saturation.
module tb_dm_cache_ctrl;
  logic        clk = 0, rst_n = 1;
  logic [31:0] addr = 0, wdata = 0, rdata = 0;
  logic        rd = 0, wr = 0, flush = 0, mem_ack = 0;
  logic [31:0] o_data, o_maddr, o_mwdata, d2_data, d2_maddr, d2_mwdata;
  logic        o_hit, o_stall, o_req, o_we, d2_hit, d2_stall, d2_req, d2_we;
  logic [15:0] hit_cnt, miss_cnt;
  logic [1:0]  hit2, miss2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .iCLK(clk), .iRST_N(rst_n), .iAddress(addr), .iWriteData(wdata), .iRead(rd), .iWrite(wr),
    .iFlush(flush), .oData(o_data), .oHit(o_hit), .oStall(o_stall), .oMemReq(o_req), .oMemWe(o_we),
    .oMemAddr(o_maddr), .oMemWData(o_mwdata), .iMemAck(mem_ack), .iMemRData(rdata),
    .oHitCount(hit_cnt), .oMissCount(miss_cnt));
  dm_cache_ctrl #(.COUNT_WIDTH(2)) dut2 (
    .iCLK(clk), .iRST_N(rst_n), .iAddress(addr), .iWriteData(wdata), .iRead(rd), .iWrite(wr),
    .iFlush(flush), .oData(d2_data), .oHit(d2_hit), .oStall(d2_stall), .oMemReq(d2_req), .oMemWe(d2_we),
    .oMemAddr(d2_maddr), .oMemWData(d2_mwdata), .iMemAck(mem_ack), .iMemRData(rdata),
    .oHitCount(hit2), .oMissCount(miss2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory responder: acks after lat extra cycles, backing store keyed by word address.
  logic [31:0] mem [logic [31:0]];
  int lat = 1, wcnt = 0;
  always @(posedge clk) begin
    #2;
    mem_ack = 0;
    if (!rst_n || !o_req) wcnt = 0;
    else if (wcnt == lat) begin
      mem_ack = 1;
      rdata = mem.exists(o_maddr) ? mem[o_maddr] : ~o_maddr;
      if (o_we) mem[o_maddr] = o_mwdata;
      wcnt = 0;
    end else wcnt++;
  end

  // Model: per-index line holding its full word address and data, plus outstanding transaction.
  bit          mvalid [256];
  logic [31:0] mline_addr [256], mline_data [256];
  int          mbusy = 0, mh = 0, mm = 0;
  logic [31:0] maddr, mdata, wa;
  logic [7:0]  ix;
  logic        h;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req", o_req, 0);
      chk("rst_stall", o_stall, 0);
      chk("rst_hit", o_hit, 0);
      chk("rst_data", o_data, 0);
      chk("rst_hitcnt", hit_cnt, 0);
      chk("rst_misscnt", miss_cnt, 0);
      foreach (mvalid[i]) mvalid[i] = 0;
      mbusy = 0; mh = 0; mm = 0;
    end else begin
      chk("hitcnt", hit_cnt, mh);
      chk("misscnt", miss_cnt, mm);
      chk("hitcnt2", hit2, mh > 3 ? 3 : mh);
      chk("misscnt2", miss2, mm > 3 ? 3 : mm);
      wa = addr & ~32'h3;
      ix = wa[9:2];
      if (mbusy == 0) begin
        h = !flush && !wr && rd && mvalid[ix] && mline_addr[ix] == wa;
        chk("idle_req", o_req, 0);
        chk("hit", o_hit, h);
        chk("data", o_data, h ? mline_data[ix] : 0);
        chk("stall", o_stall, flush || wr || (rd && !h));
        if (flush) foreach (mvalid[i]) mvalid[i] = 0;
        else if (wr) begin
          if (mvalid[ix] && mline_addr[ix] == wa) mline_data[ix] = wdata;
          mbusy = 2; maddr = wa; mdata = wdata;
        end else if (rd) begin
          if (h) mh++;
          else begin mm++; mbusy = 1; maddr = wa; end
        end
      end else begin
        chk("req", o_req, 1);
        chk("we", o_we, mbusy == 2);
        chk("maddr", o_maddr, maddr);
        if (mbusy == 2) chk("mwdata", o_mwdata, mdata);
        chk("busy_stall", o_stall, !mem_ack);
        chk("busy_hit", o_hit, 0);
        chk("busy_data", o_data, (mbusy == 1 && mem_ack) ? rdata : 0);
        if (mem_ack) begin
          if (mbusy == 1) begin
            mvalid[maddr[9:2]] = 1;
            mline_addr[maddr[9:2]] = maddr;
            mline_data[maddr[9:2]] = rdata;
          end
          mbusy = 0;
        end
      end
    end
  end

  logic        first_hit, first_stall, saw_we;
  logic [31:0] last_data, req_addr, saw_wd;
  int          cycles;
  task automatic cyc;
    @(posedge clk); #1;
  endtask
  task automatic wait_done;
    int n = 0;
    @(negedge clk);
    first_hit = o_hit; first_stall = o_stall; req_addr = 0; saw_we = 0; saw_wd = 0;
    while (o_stall && n < 50) begin
      @(negedge clk); n++;
      if (o_req) begin req_addr = o_maddr; saw_we = o_we; saw_wd = o_mwdata; end
    end
    if (n >= 50) chk("timeout", 1, 0);
    last_data = o_data; cycles = n + 1;
    cyc;
  endtask
  task automatic read_op(input logic [31:0] a);
    addr = a; rd = 1;
    wait_done;
    rd = 0;
  endtask
  task automatic write_op(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1;
    wait_done;
    wr = 0;
  endtask

  initial begin
    mem[32'h40] = 32'hDEADBEEF;
    #1 rst_n = 0;
    cyc; cyc;
    chk("lit_rst_stall", o_stall, 0);
    rst_n = 1;
    cyc;
    // Miss then hit on 0x40
    read_op(32'h40);
    chk("lit_miss_first_hit", first_hit, 0);
    chk("lit_miss_first_stall", first_stall, 1);
    chk("lit_miss_req_addr", req_addr, 32'h40);
    chk("lit_miss_data", last_data, 32'hDEADBEEF);
    chk("lit_miss_cycles", cycles, 3);
    chk("lit_misscnt1", miss_cnt, 1);
    read_op(32'h40);
    chk("lit_hit_first", first_hit, 1);
    chk("lit_hit_data", last_data, 32'hDEADBEEF);
    chk("lit_hit_cycles", cycles, 1);
    chk("lit_hitcnt1", hit_cnt, 1);
    // Write-through hit, then write miss leaves cache untouched
    write_op(32'h40, 32'h12345678);
    chk("lit_wr_we", saw_we, 1);
    chk("lit_wr_wd", saw_wd, 32'h12345678);
    chk("lit_wr_addr", req_addr, 32'h40);
    read_op(32'h40);
    chk("lit_wrhit_hit", first_hit, 1);
    chk("lit_wrhit_data", last_data, 32'h12345678);
    write_op(32'h82, 32'hCAFEF00D);
    chk("lit_wrmiss_addr", req_addr, 32'h80);
    chk("lit_wr_counts", {hit_cnt, miss_cnt}, {16'd2, 16'd1});
    read_op(32'h80);
    chk("lit_rdmiss_hit", first_hit, 0);
    chk("lit_rdmiss_data", last_data, 32'hCAFEF00D);
    // Conflict eviction with minimum latency
    lat = 0;
    read_op(32'h440);
    chk("lit_conf_data", last_data, 32'hFFFFFBBF);
    chk("lit_min_cycles", cycles, 2);
    read_op(32'h40);
    chk("lit_evict_hit", first_hit, 0);
    chk("lit_evict_data", last_data, 32'h12345678);
    chk("lit_misscnt4", miss_cnt, 4);
    chk("lit_misscnt_sat", miss2, 3);
    // Flush concurrent with a read
    read_op(32'h40);
    chk("lit_prefl_hit", first_hit, 1);
    flush = 1; rd = 1; addr = 32'h40;
    @(negedge clk);
    chk("lit_flush_stall", o_stall, 1);
    chk("lit_flush_hit", o_hit, 0);
    cyc; flush = 0;
    read_op(32'h40);
    chk("lit_postfl_hit", first_hit, 0);
    chk("lit_postfl_stall", first_stall, 1);
    // Reset two cycles into a fetch
    lat = 10; addr = 32'h100; rd = 1;
    cyc; cyc;
    @(negedge clk);
    chk("lit_fetch_req", o_req, 1);
    cyc; rst_n = 0;
    @(negedge clk);
    chk("lit_rstmid_req", o_req, 0);
    chk("lit_rstmid_stall", o_stall, 0);
    chk("lit_rstmid_cnt", miss_cnt, 0);
    cyc; rst_n = 1; rd = 0; lat = 0;
    cyc;
    read_op(32'h100);
    chk("lit_rst_refetch", first_hit, 0);
    chk("lit_rst_counts", {hit_cnt, miss_cnt}, {16'd0, 16'd1});
    for (int i = 0; i < 5; i++) read_op(32'h100);
    chk("lit_hit5", hit_cnt, 5);
    chk("lit_hit_sat", hit2, 3);
    cyc;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
